// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory stage: access size encodings,
// responder FSM states and load-data extension/lane helpers.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte enables for a store; size 11 behaves as a word.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0010;
          2'd2:    be = 4'b0100;
          default: be = 4'b1000;
        endcase
      end
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = sign ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_HALF: r = sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that only updates on read accesses.
module dmem_bram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  // Read data is held across stores so a pending load response stays stable.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MIPS M stage: byte-enabled stores, stalled loads.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module dmem_resp
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        stall_o,
  output logic        adel_o,
  output logic        ades_o
);

  localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_reg;
  logic [1:0]       size_reg;
  logic             sign_reg;

  logic [1:0]  lane;
  logic        trap;
  logic        idle;
  logic        ld_go;
  logic        st_go;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] ram_rdata;
  logic        unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_W+2];

  // Misaligned accesses either trap or get their low address bits cleared.
  always_comb begin
    lane = addr_i[1:0];
    trap = 1'b0;
    case (size_i)
      SZ_BYTE: ;
      SZ_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = addr_i[0];
`endif
        lane[0] = 1'b0;
      end
      default: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = |addr_i[1:0];
`endif
        lane = 2'b00;
      end
    endcase
  end

  assign idle  = (state == ST_IDLE) && !rst;
  assign ld_go = idle && req_i && !we_i && !trap;
  assign st_go = idle && req_i &&  we_i && !trap;

  assign adel_o = idle && req_i && !we_i && trap;
  assign ades_o = idle && req_i &&  we_i && trap;

  assign be = byte_enables(size_i, lane);

  always_comb begin
    case (size_i)
      SZ_BYTE: wdata_rep = {4{wdata_i[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_i[15:0]}};
      default: wdata_rep = wdata_i;
    endcase
  end

  dmem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk   (clk),
    .en    (ld_go || st_go),
    .we    (st_go ? be : 4'b0000),
    .addr  (addr_i[ADDR_W+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lane_reg <= 2'b00;
      size_reg <= SZ_BYTE;
      sign_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_go) begin
            lane_reg <= lane;
            size_reg <= size_i;
            sign_reg <= sign_i;
            cnt      <= WS_CNT;
            state    <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == 1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall_o  = ld_go || (state == ST_WAIT);
  assign rvalid_o = (state == ST_RESP);
  assign rdata_o  = rvalid_o ? load_extend(ram_rdata, lane_reg, size_reg, sign_reg) : 32'h0;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: one instance with WAIT_STATES=1, one with 0.
module tb_dmem_resp;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        rvalid, stall, adel, ades;

  logic        req0, we0, sign0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        rvalid0, stall0, adel0, ades0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp0_q[$];

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_W(10), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .sign_i(sign),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid),
    .stall_o(stall), .adel_o(adel), .ades_o(ades)
  );

  dmem_resp #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .size_i(size0), .sign_i(sign0),
    .addr_i(addr0), .wdata_i(wdata0), .rdata_o(rdata0), .rvalid_o(rvalid0),
    .stall_o(stall0), .adel_o(adel0), .ades_o(ades0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitors: pop the scoreboard whenever a load response appears.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'h0);
      else check("rdata", rdata, exp_q.pop_front());
    end else begin
      check("rdata_zero_idle", rdata, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (exp0_q.size() == 0) check("ws0_unexpected_rvalid", 32'(rvalid0), 32'h0);
      else check("ws0_rdata", rdata0, exp0_q.pop_front());
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input logic exp_trap);
    req = 1'b1; we = 1'b1; size = sz; addr = a; wdata = d; sign = 1'b0;
    @(negedge clk);
    check("st_stall", 32'(stall), 32'h0);
    check("st_ades", 32'(ades), 32'(exp_trap));
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    $display("store addr=%h size=%0d data=%h trap=%0b", a, sz, d, exp_trap);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                      input logic [31:0] exp_data, input logic exp_trap);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    req = 1'b1; we = 1'b0; size = sz; addr = a; sign = sg;
    if (!exp_trap) exp_q.push_back(exp_data);
    @(negedge clk);
    check("ld_adel", 32'(adel), 32'(exp_trap));
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (stall) begin
        n++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) check("ld_timeout", 32'h1, 32'h0);
    check("ld_stall_cycles", n, exp_trap ? 0 : WS + 1);
    check("ld_rvalid", 32'(rvalid), exp_trap ? 32'h0 : 32'h1);
    @(posedge clk); #1;
    req = 1'b0;
    $display("load  addr=%h size=%0d sign=%0b expect=%h trap=%0b stall_cycles=%0d",
             a, sz, sg, exp_data, exp_trap, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 0; we = 0; sign = 0; size = 2'b10; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; sign0 = 0; size0 = 2'b10; addr0 = 0; wdata0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_adel", 32'(adel), 32'h0);
    check("rst_ades", 32'(ades), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    store(32'h10, 2'b10, 32'hDEADBEEF, 0);
    load (32'h10, 2'b10, 0, 32'hDEADBEEF, 0);

    store(32'h20, 2'b10, 32'h11223344, 0);
    store(32'h21, 2'b00, 32'h00000080, 0);
    load (32'h21, 2'b00, 1, 32'hFFFFFF80, 0);
    load (32'h21, 2'b00, 0, 32'h00000080, 0);
    load (32'h20, 2'b10, 0, 32'h11228044, 0);

    store(32'h30, 2'b10, 32'hAABBCCDD, 0);
    store(32'h32, 2'b01, 32'h00008001, 0);
    load (32'h32, 2'b01, 1, 32'hFFFF8001, 0);
    load (32'h32, 2'b01, 0, 32'h00008001, 0);
    store(32'h30, 2'b01, 32'h00001234, 0);
    load (32'h30, 2'b10, 0, 32'h80011234, 0);
    load (32'h30, 2'b01, 1, 32'h00001234, 0);
    load (32'h33, 2'b00, 1, 32'hFFFFFF80, 0);
    load (32'h30, 2'b11, 0, 32'h80011234, 0);
    load (32'h00001010, 2'b10, 0, 32'hDEADBEEF, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    load (32'h13, 2'b10, 0, 32'h0, 1);
    load (32'h33, 2'b01, 0, 32'h0, 1);
    store(32'h12, 2'b10, 32'h55555555, 1);
    load (32'h10, 2'b10, 0, 32'hDEADBEEF, 0);
`else
    load (32'h13, 2'b10, 0, 32'hDEADBEEF, 0);
    load (32'h33, 2'b01, 0, 32'h00008001, 0);
    store(32'h12, 2'b10, 32'h55555555, 0);
    load (32'h10, 2'b10, 0, 32'h55555555, 0);
`endif

    // Reset asserted while the load sits in WAIT: abort with no response.
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h20; sign = 1'b0;
    @(negedge clk);
    check("abort_stall_req", 32'(stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    #1;
    check("abort_stall_async", 32'(stall), 32'h0);
    check("abort_rvalid_async", 32'(rvalid), 32'h0);
    @(negedge clk);
    check("abort_stall", 32'(stall), 32'h0);
    check("abort_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset during WAIT on load addr=00000020");
    load (32'h20, 2'b10, 0, 32'h11228044, 0);

    // Zero wait states: lw then sw to the same word, then lw again.
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 32'h40; wdata0 = 32'h01020304;
    @(negedge clk);
    check("ws0_st_stall", 32'(stall0), 32'h0);
    @(posedge clk); #1;
    we0 = 1'b0;
    exp0_q.push_back(32'h01020304);
    @(negedge clk);
    check("ws0_ld_stall", 32'(stall0), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ws0_resp_stall", 32'(stall0), 32'h0);
    check("ws0_resp_rvalid", 32'(rvalid0), 32'h1);
    @(posedge clk); #1;
    we0 = 1'b1; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    check("ws0_st2_stall", 32'(stall0), 32'h0);
    @(posedge clk); #1;
    we0 = 1'b0;
    exp0_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    check("ws0_ld2_stall", 32'(stall0), 32'h1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("ws0_ld2_rvalid", 32'(rvalid0), 32'h1);
    $display("ws0 lw/sw/lw sequence at addr=00000040 done");
    @(posedge clk); #1;

    check("scoreboard_empty", exp_q.size() + exp0_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
